tawas_dmem: RTL

TAWAS_DMEM -- requirements
Module: tawas_dmem

---
 rtl/tawas_dmem_if.sv | 25 ++
 rtl/tawas_dmem.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/tawas_dmem_if.sv
// Load/store bus between an initiator and tawas_dmem, with error and parity sideband.
interface tawas_dmem_if;
    logic [31:0] DADDR;
    logic        DCS;
    logic        DWR;
    logic [3:0]  DMASK;
    logic [31:0] DOUT;
    logic [31:0] DIN;
    logic        ERR;
    logic [31:0] ERR_ADDR;
    logic [7:0]  ERR_CNT;
    logic        ERR_CLR;
    logic        PAR_INJ;
    logic        PERR;

    modport master (
        output DADDR, DCS, DWR, DMASK, DOUT, ERR_CLR, PAR_INJ,
        input  DIN, ERR, ERR_ADDR, ERR_CNT, PERR
    );

    modport slave (
        input  DADDR, DCS, DWR, DMASK, DOUT, ERR_CLR, PAR_INJ,
        output DIN, ERR, ERR_ADDR, ERR_CNT, PERR
    );
endinterface

// File: rtl/tawas_dmem.sv
// Single-cycle data memory with a posted one-entry write buffer and out-of-window error capture.
// Optional per-byte even parity is enabled by defining TAWAS_DMEM_PARITY_EN.
module tawas_dmem #(
    parameter int unsigned AW   = 10,
    parameter logic [31:0] BASE = 32'h0000_0000
) (
    input logic         CLK,
    input logic         RST_N,
    tawas_dmem_if.slave bus
);
    localparam int unsigned Depth = 1 << AW;

    typedef enum logic [0:0] {StEmpty, StFull} wbuf_state_e;

    logic [31:0] mem [Depth];

    wbuf_state_e   wb_state;
    logic [AW-1:0] wb_idx;
    logic [3:0]    wb_mask;
    logic [31:0]   wb_data;

    logic [31:0] din_q;
    logic        err_q;
    logic [31:0] err_addr_q;
    logic [7:0]  err_cnt_q;

    logic [AW-1:0] idx;
    logic          hit;
    logic          rd_hit;
    logic          wr_hit;
    logic          miss;
    logic          fwd;
    logic [31:0]   arr_word;
    logic [31:0]   rd_word;

    assign idx      = bus.DADDR[AW+1:2];
    assign hit      = (bus.DADDR[31:AW+2] == BASE[31:AW+2]);
    assign rd_hit   = bus.DCS & ~bus.DWR & hit;
    assign wr_hit   = bus.DCS & bus.DWR & hit;
    assign miss     = bus.DCS & ~hit;
    assign fwd      = (wb_state == StFull) && (wb_idx == idx);
    assign arr_word = mem[idx];

    // The buffered entry commits on the same edge a read samples, so overlay it here.
    always_comb begin
        rd_word = arr_word;
        for (int i = 0; i < 4; i++) begin
            if (fwd && wb_mask[i]) begin
                rd_word[8*i +: 8] = wb_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wb_state   <= StEmpty;
            wb_idx     <= '0;
            wb_mask    <= '0;
            wb_data    <= '0;
            din_q      <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            din_q <= rd_hit ? rd_word : 32'h0;

            unique case (wb_state)
                StEmpty: if (wr_hit) wb_state <= StFull;
                StFull:  if (!wr_hit) wb_state <= StEmpty;
                default: wb_state <= StEmpty;
            endcase

            if (wr_hit) begin
                wb_idx  <= idx;
                wb_mask <= bus.DMASK;
                wb_data <= bus.DOUT;
            end

            // A miss wins over a simultaneous clear and restarts the capture.
            if (miss) begin
                err_q <= 1'b1;
                if (!err_q || bus.ERR_CLR) begin
                    err_addr_q <= bus.DADDR;
                end
                if (bus.ERR_CLR) begin
                    err_cnt_q <= 8'd1;
                end else if (err_cnt_q != 8'hFF) begin
                    err_cnt_q <= err_cnt_q + 8'd1;
                end
            end else if (bus.ERR_CLR) begin
                err_q      <= 1'b0;
                err_addr_q <= '0;
                err_cnt_q  <= '0;
            end
        end
    end

    // Array is not reset; a pending entry is simply dropped when reset hits.
    always_ff @(posedge CLK) begin
        if (RST_N && wb_state == StFull) begin
            for (int i = 0; i < 4; i++) begin
                if (wb_mask[i]) begin
                    mem[wb_idx][8*i +: 8] <= wb_data[8*i +: 8];
                end
            end
        end
    end

    assign bus.DIN      = din_q;
    assign bus.ERR      = err_q;
    assign bus.ERR_ADDR = err_addr_q;
    assign bus.ERR_CNT  = err_cnt_q;

`ifdef TAWAS_DMEM_PARITY_EN
    logic [3:0] par_mem [Depth];
    logic       wb_inj;
    logic       perr_q;
    logic [3:0] par_bad;

    // Only bytes that come from the array can carry a stored parity fault.
    always_comb begin
        par_bad = '0;
        for (int i = 0; i < 4; i++) begin
            if (!(fwd && wb_mask[i])) begin
                par_bad[i] = (^arr_word[8*i +: 8]) ^ par_mem[idx][i];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            perr_q <= 1'b0;
            wb_inj <= 1'b0;
        end else begin
            perr_q <= rd_hit & (|par_bad);
            if (wr_hit) begin
                wb_inj <= bus.PAR_INJ;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST_N && wb_state == StFull) begin
            for (int i = 0; i < 4; i++) begin
                if (wb_mask[i]) begin
                    par_mem[wb_idx][i] <= (^wb_data[8*i +: 8]) ^ wb_inj;
                end
            end
        end
    end

    assign bus.PERR = perr_q;
`else
    logic unused_par_inj;
    assign unused_par_inj = bus.PAR_INJ;
    assign bus.PERR       = 1'b0;
`endif

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^bus.DADDR[1:0];
endmodule
